// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 scan-code decoder with event FIFO, held-key tracking and press counter
//
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   ps2_data/ps2_ready   head byte of the receiver and its non-empty flag
//   ps2_nextdata_n       registered active-low pop strobe to the receiver
//   clr                  synchronous clear of press_count and overflow
//   ev_valid/ev_ready    show-ahead event FIFO handshake
//   ev_code/ev_ext/ev_break  head event fields
//   held/held_code/held_ext  currently held key
//   press_count          accepted make events (wrapping)
//   overflow             sticky: an event was dropped on a full FIFO
module ps2_key_decoder #(
    parameter int FIFO_DEPTH      = 8,
    parameter int CNT_W           = 8,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    output logic             ps2_nextdata_n,
    input  logic             clr,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             held,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_count,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t state, next_state;

    logic [7:0] byte_r;
    logic       byte_v;

    logic       mk_req;
    logic       bk_req;
    logic       ev_x;
    logic       is_ignored;
    logic       key_match;
    logic       make_acc;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       full;
    logic       drop;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Fetch: the strobe is low for exactly one cycle per byte and the
    // following cycle is forced high, so the receiver sees a clean pop edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ps2_nextdata_n <= 1'b1;
            byte_r         <= 8'h00;
            byte_v         <= 1'b0;
        end else if (ps2_ready && ps2_nextdata_n) begin
            byte_r         <= ps2_data;
            byte_v         <= 1'b1;
            ps2_nextdata_n <= 1'b0;
        end else begin
            byte_v         <= 1'b0;
            ps2_nextdata_n <= 1'b1;
        end
    end

    // Keyboard status/ack bytes are only meaningful outside a prefix sequence.
    assign is_ignored = byte_r inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mk_req     = 1'b0;
        bk_req     = 1'b0;
        ev_x       = 1'b0;
        if (byte_v) begin
            case (state)
                S_IDLE: begin
                    if (byte_r == 8'hE0) begin
                        next_state = S_EXT;
                    end else if (byte_r == 8'hF0) begin
                        next_state = S_BRK;
                    end else if (!is_ignored) begin
                        mk_req = 1'b1;
                    end
                end
                S_EXT: begin
                    if (byte_r == 8'hF0) begin
                        next_state = S_EXT_BRK;
                    end else if (byte_r != 8'hE0) begin
                        mk_req     = 1'b1;
                        ev_x       = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (byte_r == 8'hE0) begin
                        next_state = S_EXT_BRK;
                    end else if (byte_r != 8'hF0) begin
                        bk_req     = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (byte_r != 8'hE0 && byte_r != 8'hF0) begin
                        bk_req     = 1'b1;
                        ev_x       = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    assign key_match = held && (byte_r == held_code) && (ev_x == held_ext);
    // A typematic repeat of the held key is swallowed entirely when enabled.
    assign make_acc  = mk_req && !((SUPPRESS_REPEAT != 0) && key_match);
    assign push_req  = make_acc || bk_req;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && !push_ok;

    assign {ev_break, ev_ext, ev_code} = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {bk_req, ev_x, byte_r};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Held-key and counter updates apply even when the FIFO drops the event.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held        <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            press_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (make_acc) begin
                held      <= 1'b1;
                held_code <= byte_r;
                held_ext  <= ev_x;
            end else if (bk_req && key_match) begin
                held <= 1'b0;
            end

            if (clr) begin
                press_count <= '0;
            end else if (make_acc) begin
                press_count <= press_count + 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder (repeat-suppressing and forwarding instances)
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ev_ready;
    logic       clr;

    logic       nd0, v0, x0, b0, h0, he0, ov0;
    logic [7:0] c0, hc0, pc0;
    logic       nd1, v1, x1, b1, h1, he1, ov1;
    logic [7:0] c1, hc1, pc1;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: index 0 suppresses repeats, index 1 forwards them
    bit         m_held [2];
    logic [7:0] m_hc   [2];
    bit         m_he   [2];
    logic [7:0] m_cnt  [2];
    bit         m_ovf  [2];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    bit         pend_ext, pend_brk;

    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h15,
                              8'hAA, 8'h00, 8'h1C, 8'hF0, 8'hE0, 8'h21};
    logic [7:0] fill_codes [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    always #5 clk = ~clk;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .SUPPRESS_REPEAT(1)) dut (
        .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_nextdata_n(nd0), .clr(clr), .ev_valid(v0), .ev_ready(ev_ready),
        .ev_code(c0), .ev_ext(x0), .ev_break(b0), .held(h0), .held_code(hc0),
        .held_ext(he0), .press_count(pc0), .overflow(ov0)
    );

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .SUPPRESS_REPEAT(0)) dut_nr (
        .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_nextdata_n(nd1), .clr(clr), .ev_valid(v1), .ev_ready(ev_ready),
        .ev_code(c1), .ev_ext(x1), .ev_break(b1), .held(h1), .held_code(hc1),
        .held_ext(he1), .press_count(pc1), .overflow(ov1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_held[k] = 0; m_hc[k] = 8'h00; m_he[k] = 0; m_cnt[k] = 8'h00; m_ovf[k] = 0;
        end
        q0.delete();
        q1.delete();
        pend_ext = 0;
        pend_brk = 0;
    endtask

    task automatic model_event(input int k, input logic [7:0] code, input bit ext,
                               input bit brk, input bit clr_now);
        bit do_push = 0;
        bit dropped = 0;
        bit same    = m_held[k] && (m_hc[k] == code) && (m_he[k] == ext);
        if (!brk) begin
            if (!(k == 0 && same)) begin
                do_push   = 1;
                m_held[k] = 1;
                m_hc[k]   = code;
                m_he[k]   = ext;
                m_cnt[k]  = m_cnt[k] + 8'd1;
            end
        end else begin
            do_push = 1;
            if (same) m_held[k] = 0;
        end
        if (do_push) begin
            if (k == 0) begin
                if (q0.size() < DEPTH) q0.push_back({brk, ext, code}); else dropped = 1;
            end else begin
                if (q1.size() < DEPTH) q1.push_back({brk, ext, code}); else dropped = 1;
            end
        end
        if (dropped) m_ovf[k] = 1;
        else if (clr_now) m_ovf[k] = 0;
        if (clr_now) m_cnt[k] = 8'h00;
    endtask

    task automatic model_clr_only();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 8'h00;
            m_ovf[k] = 0;
        end
    endtask

    // Prefixes accumulate; a non-prefix byte closes the sequence as one event.
    task automatic model_byte(input logic [7:0] b, input bit clr_now);
        bit ignored = (b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF});
        if (b == 8'hE0) begin
            pend_ext = 1;
            if (clr_now) model_clr_only();
        end else if (b == 8'hF0) begin
            pend_brk = 1;
            if (clr_now) model_clr_only();
        end else if (!pend_ext && !pend_brk && ignored) begin
            if (clr_now) model_clr_only();
        end else begin
            model_event(0, b, pend_ext, pend_brk, clr_now);
            model_event(1, b, pend_ext, pend_brk, clr_now);
            pend_ext = 0;
            pend_brk = 0;
        end
    endtask

    task automatic check_state();
        chk("held_s", h0, m_held[0]);   chk("held_n", h1, m_held[1]);
        chk("hcode_s", hc0, m_hc[0]);   chk("hcode_n", hc1, m_hc[1]);
        chk("hext_s", he0, m_he[0]);    chk("hext_n", he1, m_he[1]);
        chk("count_s", pc0, m_cnt[0]);  chk("count_n", pc1, m_cnt[1]);
        chk("ovf_s", ov0, m_ovf[0]);    chk("ovf_n", ov1, m_ovf[1]);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_strobe"}, {nd0, nd1}, 2'b11);
        chk({p, "_valid"}, {v0, v1}, 2'b00);
        chk({p, "_head_s"}, {b0, x0, c0}, 10'h000);
        chk({p, "_head_n"}, {b1, x1, c1}, 10'h000);
        chk({p, "_held"}, {h0, hc0, he0, h1, hc1, he1}, 20'h0);
        chk({p, "_count"}, {pc0, pc1}, 16'h0);
        chk({p, "_ovf"}, {ov0, ov1}, 2'b00);
    endtask

    // Starts and ends 1 time unit after a rising edge; returns after the push edge.
    task automatic send(input logic [7:0] b, input int gap, input bit pop_now, input bit clr_now);
        bit got = 0;
        repeat (gap) begin @(posedge clk); #1; end
        ps2_data  = b;
        ps2_ready = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (nd0 === 1'b0) got = 1;
        end
        ps2_ready = 1'b0;
        chk("fetch_strobe", got, 1);
        if (!got) return;
        chk("strobe_low_n", nd1, 1'b0);
        if (pop_now) begin
            if (q0.size() > 0) begin
                chk("pop_head_s", {b0, x0, c0}, q0[0]);
                void'(q0.pop_front());
            end
            if (q1.size() > 0) begin
                chk("pop_head_n", {b1, x1, c1}, q1[0]);
                void'(q1.pop_front());
            end
            ev_ready = 1'b1;
        end
        clr = clr_now;
        model_byte(b, clr_now);
        @(posedge clk); #1;
        ev_ready = 1'b0;
        clr      = 1'b0;
        chk("strobe_high", {nd0, nd1}, 2'b11);
        check_state();
    endtask

    task automatic drain();
        int guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 2 * DEPTH + 2) begin
            guard++;
            if (q0.size() > 0) begin
                chk("ev_valid_s", v0, 1'b1);
                chk("ev_head_s", {b0, x0, c0}, q0[0]);
                void'(q0.pop_front());
            end
            if (q1.size() > 0) begin
                chk("ev_valid_n", v1, 1'b1);
                chk("ev_head_n", {b1, x1, c1}, q1[0]);
                void'(q1.pop_front());
            end
            ev_ready = 1'b1;
            @(posedge clk); #1;
            ev_ready = 1'b0;
        end
        chk("drained_s", v0, 1'b0);
        chk("drained_n", v1, 1'b0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        model_clr_only();
        @(posedge clk); #1;
        clr = 1'b0;
        check_state();
    endtask

    initial begin
        resetn    = 1'b0;
        ps2_data  = 8'h00;
        ps2_ready = 1'b0;
        ev_ready  = 1'b0;
        clr       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // make then break of a plain key
        send(8'h1C, 0, 0, 0);
        send(8'hF0, 1, 0, 0);
        send(8'h1C, 0, 0, 0);
        drain();

        // extended make and break
        send(8'hE0, 0, 0, 0);
        send(8'h75, 0, 0, 0);
        send(8'hE0, 2, 0, 0);
        send(8'hF0, 0, 0, 0);
        send(8'h75, 0, 0, 0);
        drain();

        // typematic repeats
        send(8'h15, 0, 0, 0);
        send(8'h15, 0, 0, 0);
        send(8'h15, 0, 0, 0);
        send(8'hF0, 0, 0, 0);
        send(8'h15, 0, 0, 0);
        drain();

        // six makes into a four-deep queue
        for (int i = 0; i < 6; i++) send(fill_codes[i], 0, 0, 0);
        drain();

        // full queue with a pop on the push edge
        pulse_clr();
        for (int i = 0; i < 4; i++) send(fill_codes[i], 0, 0, 0);
        send(8'h24, 0, 1, 0);
        drain();

        // clear coinciding with a drop
        for (int i = 0; i < 4; i++) send(fill_codes[i], 0, 0, 0);
        send(8'h24, 0, 0, 1);
        drain();
        pulse_clr();

        // reset in the middle of an extended break sequence
        send(8'h1C, 0, 0, 0);
        send(8'hE0, 0, 0, 0);
        send(8'hF0, 0, 0, 0);
        resetn = 1'b0;
        #1;
        check_reset("midreset");
        model_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        send(8'hF0, 0, 0, 0);
        send(8'h1C, 0, 0, 0);
        drain();

        // randomized byte streams with occasional clears and same-edge pops
        for (int n = 0; n < 30; n++) begin
            int len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                send(pool[$urandom_range(0, 11)], $urandom_range(0, 2),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
            end
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 Set-2 scan-code decoder between the `ps2_keyboard` byte receiver and the display/LED logic. It replaces ad-hoc make/break handling in the top level. It pops bytes from the receiver and parses `E0` (extended) and `F0` (break) prefixes into single key events. Events are queued in a show-ahead FIFO with a valid/ready handshake. The block also tracks the currently held key, optionally suppresses typematic repeats, and counts key presses.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO depth. Must be a power of 2 and ≥2.
- `CNT_W`, default 8: width of `press_count`.
- `SUPPRESS_REPEAT`, default 1: 1 drops repeated make codes of the held key; 0 forwards every make code.

- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `ps2_data`  in  8  receiver head byte; valid while `ps2_ready`=1.
- `ps2_ready`  in  1  receiver has ≥1 byte.
- `ps2_nextdata_n`  out  1  active-low pop strobe to the receiver; registered.
- `clr`  in  1  synchronous clear of `press_count` and `overflow`.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_code`  out  8  head event scan code.
- `ev_ext`  out  1  head event was `E0`-prefixed.
- `ev_break`  out  1  head event is a release (1) or a press (0).
- `held`  out  1  a key is currently held.
- `held_code`  out  8  last pressed key code.
- `held_ext`  out  1  extended flag of the held key.
- `press_count`  out  CNT_W  accepted make events, modulo 2^CNT_W.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- **Fetch**
  - At an edge where `ps2_ready`=1 and `ps2_nextdata_n`=1: latch `ps2_data` into `byte_r`, set `byte_v`, and drive `ps2_nextdata_n` to 0 for exactly one cycle.
  - Then force one cycle with `ps2_nextdata_n`=1.
  - Maximum rate: one byte per 2 cycles.
- **Parser FSM**: states IDLE, EXT, BRK, EXT_BRK. Transitions act on `byte_v`.
  - IDLE:
    - `E0` → EXT.
    - `F0` → BRK.
    - `E1`, `AA`, `FA`, `EE`, `FE`, `00`, `FF` → discarded, stay IDLE.
    - Any other byte → make event (ext=0), stay IDLE.
  - EXT:
    - `F0` → EXT_BRK.
    - `E0` → stay EXT.
    - Other → make event (ext=1) → IDLE.
  - BRK:
    - `F0` → stay BRK.
    - `E0` → EXT_BRK.
    - Other → break event (ext=0) → IDLE.
  - EXT_BRK:
    - `E0`/`F0` → stay EXT_BRK.
    - Other → break event (ext=1) → IDLE.
- **Make event**
  - If `SUPPRESS_REPEAT`=1, `held`=1, and {code, ext} equals {`held_code`, `held_ext`}: the event is suppressed (no push, no count).
  - Otherwise: push the event, set `held`, load `held_code`/`held_ext`, and increment `press_count` (wraps to 0).
- **Break event**
  - Always pushed.
  - Clears `held` only if {code, ext} equals the held key; other releases leave `held` unchanged.
- **FIFO**
  - Pop on `ev_valid & ev_ready`.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` is set. Held-key and count updates still apply.
- **`clr`**
  - Zeroes `press_count`; `clr` wins over a same-cycle increment.
  - Clears `overflow`; a same-cycle drop wins and `overflow` stays 1.

## Timing
- Reset values:
  - `ps2_nextdata_n`=1.
  - `ev_valid`=0, `ev_code`=0, `ev_ext`=0, `ev_break`=0 (empty FIFO, head register zero).
  - `held`=0, `held_code`=0, `held_ext`=0.
  - `press_count`=0, `overflow`=0.
  - FSM in IDLE, `byte_v`=0.
- Latency:
  - Byte latched at edge E.
  - FSM transition and FIFO write at edge E+1.
  - If the FIFO was empty, `ev_valid`=1 and head outputs are valid after E+1.
  - A three-byte break sequence therefore completes 1 cycle after its last byte is latched.
- FIFO outputs are show-ahead: head fields are stable while `ev_valid`=1 and `ev_ready`=0.
- `held`, `held_code`, `press_count` update at edge E+1, the same edge as the push.
- A mid-operation reset asynchronously returns all state to reset values. Any partial prefix sequence and all queued events are lost. A byte with an in-flight pop strobe may be lost.

## Test plan
- Bytes `1C` then `F0 1C`, `ev_ready`=1: events {1C, ext0, make} then {1C, ext0, break}; `press_count`=1; `held` 1→0; `ps2_nextdata_n` pulses low once per byte.
- Bytes `E0 75`, `E0 F0 75`: events {75, ext1, make}, {75, ext1, break}; `held_ext`=1 while held.
- `SUPPRESS_REPEAT`=1, bytes `15 15 15 F0 15`: exactly 2 events, `press_count`=1. Repeat with `SUPPRESS_REPEAT`=0: 4 events, `press_count`=3.
- `ev_ready`=0, `FIFO_DEPTH`=4, six make codes `1C 32 21 23 24 2B`:
  - Queue holds `1C 32 21 23`; `overflow`=1; `press_count`=6.
  - Then `ev_ready`=1: events drain in order, `ev_valid` falls after the 4th.
- FIFO full with `ev_ready`=1 and a push in the same cycle: push is accepted, `overflow` stays 0. `clr` in the cycle of a drop: `overflow`=1, `press_count`=0.
- Assert `resetn`=0 after `E0 F0` (before the final byte): all outputs return to reset values. A following `F0 1C` yields {1C, ext0, break}.
